// File: rtl/softex_tcdm_aligner_if.sv
// Bus bundle between the softex streamer (wide HCI side), the aligner and the
// MP narrow TCDM ports. Signal names carry the aligner's point of view
// (_i = into the aligner, _o = out of the aligner).
//   slave  : the aligner itself
//   master : the environment (streamer + TCDM interconnect)
// Wide side : req/gnt, add, wen, be, data, id, r_valid/r_ready/r_data/r_id
// TCDM side : per-port req/gnt/add/wen/be/data and r_ready/r_valid/r_data
interface softex_tcdm_aligner_if #(
  parameter int unsigned MP   = 4,
  parameter int unsigned ID_W = 8
) ();
  logic                req_i;
  logic                gnt_o;
  logic [31:0]         add_i;
  logic                wen_i;
  logic [4*MP-1:0]     be_i;
  logic [32*MP-1:0]    data_i;
  logic [ID_W-1:0]     id_i;
  logic                r_valid_o;
  logic                r_ready_i;
  logic [32*MP-1:0]    r_data_o;
  logic [ID_W-1:0]     r_id_o;

  logic [MP-1:0]       tcdm_req_o;
  logic [MP-1:0]       tcdm_gnt_i;
  logic [MP*32-1:0]    tcdm_add_o;
  logic [MP-1:0]       tcdm_wen_o;
  logic [MP*4-1:0]     tcdm_be_o;
  logic [MP*32-1:0]    tcdm_data_o;
  logic [MP-1:0]       tcdm_r_ready_o;
  logic [MP*32-1:0]    tcdm_r_data_i;
  logic [MP-1:0]       tcdm_r_valid_i;

  modport slave (
    input  req_i, add_i, wen_i, be_i, data_i, id_i, r_ready_i,
           tcdm_gnt_i, tcdm_r_data_i, tcdm_r_valid_i,
    output gnt_o, r_valid_o, r_data_o, r_id_o,
           tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o, tcdm_r_ready_o
  );

  modport master (
    output req_i, add_i, wen_i, be_i, data_i, id_i, r_ready_i,
           tcdm_gnt_i, tcdm_r_data_i, tcdm_r_valid_i,
    input  gnt_o, r_valid_o, r_data_o, r_id_o,
           tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o, tcdm_r_ready_o
  );
endinterface

// File: rtl/softex_tcdm_aligner.sv
// Splits one wide HCI request into MP 32-bit TCDM requests, tracks per-port
// grants until every port has been granted, and realigns the per-port read
// responses into one wide response beat. A credit counter bounds outstanding
// wide transactions so the per-port response FIFOs cannot overflow.
// Ports:
//   clk_i, rst_ni (async, active low), clear_i (sync soft clear)
//   bus    : softex_tcdm_aligner_if.slave (wide side + TCDM side)
//   busy_o : outstanding work present
//   err_o  : sticky, a response was pushed into a full FIFO
//
// state   | meaning
// IDLE    | no port of the current wide request granted yet
// PARTIAL | some ports granted, waiting for the rest
module softex_tcdm_aligner #(
  parameter int unsigned MP         = 4,
  parameter int unsigned RESP_DEPTH = 2,
  parameter int unsigned ID_W       = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  softex_tcdm_aligner_if.slave  bus,
  output logic                  busy_o,
  output logic                  err_o
);
  localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RESP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RESP_DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, PARTIAL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [MP-1:0]     gm_q, gm_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;

  logic [31:0]       dmem_q [MP][RESP_DEPTH];
  logic [31:0]       dmem_d [MP][RESP_DEPTH];
  logic [PTR_W-1:0]  dwptr_q [MP], dwptr_d [MP];
  logic [PTR_W-1:0]  drptr_q [MP], drptr_d [MP];
  logic [CNT_W-1:0]  dcnt_q  [MP], dcnt_d  [MP];

  // The id FIFO occupancy always equals count_q, so it needs no counter.
  logic [ID_W-1:0]   idmem_q [RESP_DEPTH], idmem_d [RESP_DEPTH];
  logic [PTR_W-1:0]  id_wptr_q, id_wptr_d, id_rptr_q, id_rptr_d;

  logic              can_issue, done, gnt, r_valid, pop;
  logic [MP-1:0]     tcdm_req, new_gnt, fifo_nempty, push_ok, drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    can_issue = (count_q < DEPTH_C);
    tcdm_req  = {MP{bus.req_i & can_issue}} & ~gm_q;
    new_gnt   = tcdm_req & bus.tcdm_gnt_i;
    done      = &(gm_q | new_gnt);
    gnt       = bus.req_i & can_issue & done;
    for (int i = 0; i < MP; i++) fifo_nempty[i] = (dcnt_q[i] != '0);
    r_valid   = &fifo_nempty;
    pop       = r_valid & bus.r_ready_i;
  end

  always_comb begin
    state_d   = state_q;
    gm_d      = gm_q;
    count_d   = count_q;
    err_d     = err_q;
    dmem_d    = dmem_q;
    dwptr_d   = dwptr_q;
    drptr_d   = drptr_q;
    dcnt_d    = dcnt_q;
    idmem_d   = idmem_q;
    id_wptr_d = id_wptr_q;
    id_rptr_d = id_rptr_q;
    push_ok   = '0;
    drop      = '0;

    if (gnt) begin
      gm_d    = '0;
      state_d = IDLE;
    end else begin
      gm_d    = gm_q | new_gnt;
      state_d = (gm_d != '0) ? PARTIAL : IDLE;
    end

    count_d = count_q + CNT_W'(gnt) - CNT_W'(pop);

    if (gnt) begin
      idmem_d[id_wptr_q] = bus.id_i;
      id_wptr_d          = ptr_inc(id_wptr_q);
    end
    if (pop) id_rptr_d = ptr_inc(id_rptr_q);

    for (int i = 0; i < MP; i++) begin
      // A full FIFO still accepts a push when its head leaves in the same cycle.
      drop[i]    = bus.tcdm_r_valid_i[i] & (dcnt_q[i] == DEPTH_C) & ~pop;
      push_ok[i] = bus.tcdm_r_valid_i[i] & ~drop[i];
      if (push_ok[i]) begin
        dmem_d[i][dwptr_q[i]] = bus.tcdm_r_data_i[32*i +: 32];
        dwptr_d[i]            = ptr_inc(dwptr_q[i]);
      end
      if (pop) drptr_d[i] = ptr_inc(drptr_q[i]);
      dcnt_d[i] = dcnt_q[i] + CNT_W'(push_ok[i]) - CNT_W'(pop);
    end

    err_d = err_q | (|drop);

    if (clear_i) begin
      state_d   = IDLE;
      gm_d      = '0;
      count_d   = '0;
      err_d     = 1'b0;
      dwptr_d   = '{default: '0};
      drptr_d   = '{default: '0};
      dcnt_d    = '{default: '0};
      id_wptr_d = '0;
      id_rptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      gm_q      <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      dwptr_q   <= '{default: '0};
      drptr_q   <= '{default: '0};
      dcnt_q    <= '{default: '0};
      id_wptr_q <= '0;
      id_rptr_q <= '0;
    end else begin
      state_q   <= state_d;
      gm_q      <= gm_d;
      count_q   <= count_d;
      err_q     <= err_d;
      dwptr_q   <= dwptr_d;
      drptr_q   <= drptr_d;
      dcnt_q    <= dcnt_d;
      id_wptr_q <= id_wptr_d;
      id_rptr_q <= id_rptr_d;
    end
  end

  // Storage is only ever read through valid pointers, so it needs no reset.
  always_ff @(posedge clk_i) begin
    dmem_q  <= dmem_d;
    idmem_q <= idmem_d;
  end

  for (genvar i = 0; i < MP; i++) begin : g_port
    assign bus.tcdm_add_o[32*i +: 32] = bus.add_i + 32'(4 * i);
    assign bus.r_data_o[32*i +: 32]   = dmem_q[i][drptr_q[i]];
  end

  assign bus.gnt_o          = gnt;
  assign bus.tcdm_req_o     = tcdm_req;
  assign bus.tcdm_wen_o     = {MP{bus.wen_i}};
  assign bus.tcdm_be_o      = bus.be_i;
  assign bus.tcdm_data_o    = bus.data_i;
  assign bus.tcdm_r_ready_o = {MP{1'b1}};
  assign bus.r_valid_o      = r_valid;
  assign bus.r_id_o         = idmem_q[id_rptr_q];
  assign busy_o             = (state_q != IDLE) | (count_q != '0) | bus.req_i;
  assign err_o              = err_q;

  // Once any port is granted, the wide request must stay up until it completes.
  a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
                               (state_q == PARTIAL) |-> bus.req_i);
endmodule
